// File: rtl/sentinel_wb_pkg.sv
// Shared types and bus widths for the Sentinel Wishbone arbiter slice.
package sentinel_wb_pkg;

  localparam int WB_ADR_W = 30;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } arb_state_e;

  function automatic logic [1:0] grant_of(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sentinel_wb_arbiter_if.sv
// Wishbone classic link; master drives the request, slave returns data and termination.
interface sentinel_wb_arbiter_if;
  import sentinel_wb_pkg::*;

  logic                cyc;
  logic                stb;
  logic                we;
  logic [WB_ADR_W-1:0] adr;
  logic [WB_SEL_W-1:0] sel;
  logic [WB_DAT_W-1:0] dat_w;
  logic [WB_DAT_W-1:0] dat_r;
  logic                ack;
  logic                err;

  modport master (output cyc, stb, we, adr, sel, dat_w, input dat_r, ack, err);
  modport slave  (input cyc, stb, we, adr, sel, dat_w, output dat_r, ack, err);

endinterface

// File: rtl/sentinel_wb_watchdog.sv
// Wait-state counter: counts slave cycles without ack and flags the last allowed one.
module sentinel_wb_watchdog #(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt_reg;

  // Saturates at CNT_LAST so a held cycle can never wrap back to a safe count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (run && (cnt_reg != CNT_LAST)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign expire = run && (cnt_reg == CNT_LAST);

endmodule

// File: rtl/sentinel_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter with a bus watchdog that aborts stuck slave cycles.
module sentinel_wb_arbiter
  import sentinel_wb_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  sentinel_wb_arbiter_if.slave        m0,
  sentinel_wb_arbiter_if.slave        m1,
  sentinel_wb_arbiter_if.master       s,
  output logic [1:0]                  grant,
  output logic                        timeout_pulse
);

  arb_state_e state_reg, state_next;
  logic       owner_reg, owner_next;
  logic       last_reg, last_next;
  logic       abort_first_reg;
  logic       owner_cyc;
  logic       busy;
  logic       expire;
  logic       wd_run;
  logic       wd_clr;

  assign owner_cyc = owner_reg ? m1.cyc : m0.cyc;
  assign busy      = (state_reg == BUSY);
  assign wd_run    = s.cyc & ~s.ack;
  assign wd_clr    = s.ack | ~busy;

  sentinel_wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (wd_run),
    .clr    (wd_clr),
    .expire (expire)
  );

  // last starts at 1 so master 0 wins the first tie after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      owner_reg       <= 1'b0;
      last_reg        <= 1'b1;
      abort_first_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      owner_reg       <= owner_next;
      last_reg        <= last_next;
      abort_first_reg <= busy && (state_next == ABORT);
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    case (state_reg)
      IDLE: begin
        if (m0.cyc || m1.cyc) begin
          state_next = BUSY;
          owner_next = (m0.cyc && m1.cyc) ? ~last_reg : m1.cyc;
        end
      end
      BUSY: begin
        if (!owner_cyc) begin
          state_next = IDLE;
          last_next  = owner_reg;
        end else if (expire) begin
          state_next = ABORT;
        end
      end
      ABORT: begin
        if (!owner_cyc) begin
          state_next = IDLE;
          last_next  = owner_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The slave only sees the owner while BUSY; ABORT keeps the grant but releases the bus.
  always_comb begin
    s.cyc         = 1'b0;
    s.stb         = 1'b0;
    s.we          = 1'b0;
    s.adr         = '0;
    s.sel         = '0;
    s.dat_w       = '0;
    m0.ack        = 1'b0;
    m0.err        = 1'b0;
    m0.dat_r      = '0;
    m1.ack        = 1'b0;
    m1.err        = 1'b0;
    m1.dat_r      = '0;
    grant         = 2'b00;
    timeout_pulse = abort_first_reg;
    if (state_reg != IDLE) begin
      grant = grant_of(owner_reg);
    end
    if (busy) begin
      if (owner_reg) begin
        s.cyc    = m1.cyc;
        s.stb    = m1.stb;
        s.we     = m1.we;
        s.adr    = m1.adr;
        s.sel    = m1.sel;
        s.dat_w  = m1.dat_w;
        m1.ack   = m1.cyc & s.ack;
        m1.dat_r = s.dat_r;
      end else begin
        s.cyc    = m0.cyc;
        s.stb    = m0.stb;
        s.we     = m0.we;
        s.adr    = m0.adr;
        s.sel    = m0.sel;
        s.dat_w  = m0.dat_w;
        m0.ack   = m0.cyc & s.ack;
        m0.dat_r = s.dat_r;
      end
    end
    if (abort_first_reg) begin
      if (owner_reg) begin
        m1.err = 1'b1;
      end else begin
        m0.err = 1'b1;
      end
    end
  end

endmodule
